// File: rtl/varlat_interco_pkg.sv
// Shared constants and helpers for the variable-latency buffered interconnect.
// Imported by the arbiter, the tracking FIFO users and the top level.
package varlat_interco_pkg;

  localparam int unsigned DefNumIn          = 4;
  localparam int unsigned DefNumOut         = 4;
  localparam int unsigned DefAddrWidth      = 32;
  localparam int unsigned DefDataWidth      = 32;
  localparam int unsigned DefAddrMemWidth   = 12;
  localparam int unsigned DefNumOutstanding = 2;
  localparam int unsigned DefBlockWords     = 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO used to track in-flight transactions.
// Pushes are dropped while full, even when a pop happens in the same cycle.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       rd_ptr;
  logic [PtrW-1:0]       wr_ptr;
  logic [CntW-1:0]       cnt;
  logic                  bypass;
  logic                  wr_en;
  logic                  rd_en;

  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt == CntW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
  assign wr_en   = push_i && !full_o && !bypass;
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      if (wr_en && !rd_en) cnt <= cnt + 1'b1;
      else if (!wr_en && rd_en) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/varlat_rr_arb.sv
// Round-robin arbiter for one bank.
// Pointer moves to one past the winner only when the caller says so.
module varlat_rr_arb
  import varlat_interco_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = idx_width(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              adv_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              vld_o
);

  logic [IdxW-1:0] ptr;
  logic [IdxW-1:0] cand;

  // first requester at or after the pointer wins
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(ptr) + off) % NumReq);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o = vld_o ? (NumReq'(1) << idx_o) : '0;
  end

  // pointer update on accepted transfers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (adv_i && vld_o) begin
      ptr <= (32'(idx_o) == NumReq - 1) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/varlat_buffered_interco.sv
// N-to-M word-interleaved interconnect for variable-latency banks.
// Define VARLAT_BUFFERED_INTERCO_RSP_REG_EN for a registered response path.
module varlat_buffered_interco
  import varlat_interco_pkg::*;
#(
  parameter int unsigned NumIn          = DefNumIn,
  parameter int unsigned NumOut         = DefNumOut,
  parameter int unsigned AddrWidth      = DefAddrWidth,
  parameter int unsigned DataWidth      = DefDataWidth,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned AddrMemWidth   = DefAddrMemWidth,
  parameter int unsigned NumOutstanding = DefNumOutstanding,
  parameter int unsigned BlockWords     = DefBlockWords,
  parameter int unsigned ByteOffWidth   = $clog2(DataWidth - 1) - 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumIn-1:0]        req_i,
  output logic [NumIn-1:0]        gnt_o,
  input  logic [AddrWidth-1:0]    add_i [NumIn],
  input  logic [NumIn-1:0]        we_i,
  input  logic [DataWidth-1:0]    wdata_i [NumIn],
  input  logic [BeWidth-1:0]      be_i [NumIn],
  output logic [NumIn-1:0]        vld_o,
  input  logic [NumIn-1:0]        rready_i,
  output logic [DataWidth-1:0]    rdata_o [NumIn],
  output logic [NumOut-1:0]       req_o,
  input  logic [NumOut-1:0]       gnt_i,
  output logic [AddrMemWidth-1:0] add_o [NumOut],
  output logic [NumOut-1:0]       we_o,
  output logic [DataWidth-1:0]    wdata_o [NumOut],
  output logic [BeWidth-1:0]      be_o [NumOut],
  input  logic [NumOut-1:0]       rvalid_i,
  output logic [NumOut-1:0]       rready_o,
  input  logic [DataWidth-1:0]    rdata_i [NumOut]
);

  localparam int unsigned BankBits = $clog2(NumOut);
  localparam int unsigned BlkBits  = $clog2(BlockWords);
  localparam int unsigned SelLsb   = ByteOffWidth + BlkBits;
  localparam int unsigned IniW     = idx_width(NumIn);
  localparam int unsigned BnkW     = idx_width(NumOut);

  logic [BnkW-1:0]         bank_sel [NumIn];
  logic [AddrMemWidth-1:0] mem_addr [NumIn];
  logic [NumIn-1:0]        arb_req  [NumOut];
  logic [NumIn-1:0]        arb_gnt  [NumOut];
  logic [IniW-1:0]         arb_idx  [NumOut];
  logic [NumOut-1:0]       arb_vld;
  logic [NumOut-1:0]       acc;
  logic [NumOut-1:0]       fire;

  logic [NumIn-1:0]  ini_push;
  logic [NumIn-1:0]  ini_pop;
  logic [NumIn-1:0]  ini_full;
  logic [NumIn-1:0]  ini_empty;
  logic [BnkW-1:0]   ini_head [NumIn];
  logic [NumOut-1:0] bnk_full;
  logic [NumOut-1:0] bnk_empty;
  logic [IniW-1:0]   bnk_head [NumOut];
  logic [NumIn-1:0]  rsp_ok;

  // split byte address into bank select and in-bank word address
  always_comb begin
    for (int i = 0; i < NumIn; i++) begin
      bank_sel[i] = BnkW'((add_i[i] >> SelLsb) & AddrWidth'(NumOut - 1));
      mem_addr[i] = AddrMemWidth'(
        ((add_i[i] >> (SelLsb + BankBits)) << BlkBits) |
        ((add_i[i] >> ByteOffWidth) & AddrWidth'(BlockWords - 1)));
    end
  end

  // initiators with a full tracking FIFO drop out of arbitration
  always_comb begin
    for (int k = 0; k < NumOut; k++) begin
      for (int i = 0; i < NumIn; i++) begin
        arb_req[k][i] = req_i[i] && !ini_full[i] &&
                        (bank_sel[i] == BnkW'(k));
      end
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_bank
    varlat_rr_arb #(
      .NumReq (NumIn)
    ) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (arb_req[k]),
      .adv_i  (acc[k]),
      .gnt_o  (arb_gnt[k]),
      .idx_o  (arb_idx[k]),
      .vld_o  (arb_vld[k])
    );

    fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (IniW),
      .DEPTH        (NumOutstanding)
    ) i_bnk_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (acc[k]),
      .data_i  (arb_idx[k]),
      .pop_i   (fire[k]),
      .data_o  (bnk_head[k]),
      .full_o  (bnk_full[k]),
      .empty_o (bnk_empty[k])
    );
  end

  for (genvar i = 0; i < NumIn; i++) begin : g_ini
    fifo_v3 #(
      .FALL_THROUGH (1'b0),
      .DATA_WIDTH   (BnkW),
      .DEPTH        (NumOutstanding)
    ) i_ini_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (ini_push[i]),
      .data_i  (bank_sel[i]),
      .pop_i   (ini_pop[i]),
      .data_o  (ini_head[i]),
      .full_o  (ini_full[i]),
      .empty_o (ini_empty[i])
    );
  end

  // forward winners to banks and return grants to initiators
  always_comb begin
    req_o = '0;
    acc   = '0;
    gnt_o = '0;
    for (int k = 0; k < NumOut; k++) begin
      req_o[k]   = arb_vld[k] && !bnk_full[k];
      acc[k]     = req_o[k] && gnt_i[k] && rst_ni;
      add_o[k]   = mem_addr[arb_idx[k]];
      we_o[k]    = we_i[arb_idx[k]];
      wdata_o[k] = wdata_i[arb_idx[k]];
      be_o[k]    = be_i[arb_idx[k]];
      if (acc[k]) gnt_o = gnt_o | arb_gnt[k];
    end
  end

  assign ini_push = gnt_o;

  // a bank may answer only if it is next in line for its initiator
  always_comb begin
    rready_o = '0;
    fire     = '0;
    for (int k = 0; k < NumOut; k++) begin
      rready_o[k] = !bnk_empty[k] &&
                    !ini_empty[bnk_head[k]] &&
                    (ini_head[bnk_head[k]] == BnkW'(k)) &&
                    rsp_ok[bnk_head[k]];
      fire[k] = rvalid_i[k] && rready_o[k];
    end
  end

  // retire the initiator-side entry of each completed response
  always_comb begin
    ini_pop = '0;
    for (int i = 0; i < NumIn; i++) begin
      ini_pop[i] = !ini_empty[i] && fire[ini_head[i]] &&
                   (bnk_head[ini_head[i]] == IniW'(i));
    end
  end

`ifdef VARLAT_BUFFERED_INTERCO_RSP_REG_EN
  logic [NumIn-1:0]     rsp_vld;
  logic [DataWidth-1:0] rsp_data [NumIn];

  assign rsp_ok = ~rsp_vld | rready_i;
  assign vld_o  = rsp_vld;

  // one-entry response register per initiator
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_vld <= '0;
      for (int i = 0; i < NumIn; i++) rsp_data[i] <= '0;
    end else begin
      for (int i = 0; i < NumIn; i++) begin
        if (ini_pop[i]) begin
          rsp_vld[i]  <= 1'b1;
          rsp_data[i] <= rdata_i[ini_head[i]];
        end else if (rready_i[i]) begin
          rsp_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // registered read data
  always_comb begin
    for (int i = 0; i < NumIn; i++) rdata_o[i] = rsp_data[i];
  end
`else
  assign rsp_ok = rready_i;
  assign vld_o  = ini_pop;

  // pass the head bank's data straight through
  always_comb begin
    for (int i = 0; i < NumIn; i++) rdata_o[i] = rdata_i[ini_head[i]];
  end
`endif

endmodule
